// File: rtl/led_sweep_pwm.sv
`default_nettype none
// ============================================================================
// Module      : led_sweep_pwm
// Description : N-channel LED sweep generator with per-channel PWM dimming.
//               A fractional "bright spot" position moves across the LED bank
//               and cross-fades between neighbouring channels. The sweep
//               can bounce, wrap, freeze or be switched off at run time, and
//               its step size is also set at run time.
// Ports       : clk     - single clock
//               rst     - asynchronous, active-high reset
//               mode_i  - 0 bounce, 1 wrap, 2 freeze, 3 off
//               step_i  - position increment per update tick (0 = no motion)
//               led_o   - registered PWM LED drive, one bit per channel
//               dir_o   - sweep direction (0 up, 1 down)
//               pos_o   - position; segment = pos_o[POS_W-1:FRAC_W]
// Revision    : 1.0 - initial release
// ============================================================================
module led_sweep_pwm #(
  parameter int N_LED  = 8,
  parameter int PWM_W  = 10,
  parameter int FRAC_W = 13,
  parameter int PRESC  = 1,
  parameter int STEP_W = 4,
  localparam int SEG_W = $clog2(N_LED),
  localparam int POS_W = SEG_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [N_LED-1:0]  led_o,
  output logic              dir_o,
  output logic [POS_W-1:0]  pos_o
);

  localparam int C_POS_MAX = N_LED * (2 ** FRAC_W) - 1;
  localparam int C_PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [C_PRESC_W-1:0] C_PRESC_LAST = C_PRESC_W'(PRESC - 1);
  localparam logic [POS_W:0]       C_POS_MAX_X  = (POS_W + 1)'(C_POS_MAX);
  localparam logic [POS_W:0]       C_POS_MOD_X  = (POS_W + 1)'(C_POS_MAX + 1);
  localparam logic [PWM_W-1:0]     C_MAXB       = '1;

  localparam logic [1:0] C_MODE_BOUNCE = 2'd0;
  localparam logic [1:0] C_MODE_WRAP   = 2'd1;
  localparam logic [1:0] C_MODE_FREEZE = 2'd2;
  localparam logic [1:0] C_MODE_OFF    = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [C_PRESC_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0]     pwm_ctr_q, pwm_ctr_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 dir_q, dir_d;

  logic                 tick;
  logic [POS_W:0]       pos_x;
  logic [POS_W:0]       step_x;
  logic [POS_W:0]       sum_x;

  assign tick = (presc_q == C_PRESC_LAST);

  // One extra bit of headroom so pos+step never overflows before the
  // clamp/modulo comparison.
  assign pos_x  = {1'b0, pos_q};
  assign step_x = (POS_W + 1)'(step_i);
  assign sum_x  = pos_x + step_x;

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    pwm_ctr_d = pwm_ctr_q + 1'b1;
  end

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (tick) begin
      case (mode_i)
        C_MODE_BOUNCE: begin
          if (!dir_q) begin
            // Reaching the top and turning round happen on the same tick.
            if (sum_x >= C_POS_MAX_X) begin
              pos_d = C_POS_MAX_X[POS_W-1:0];
              dir_d = 1'b1;
            end else begin
              pos_d = sum_x[POS_W-1:0];
            end
          end else begin
            if (pos_x <= step_x) begin
              pos_d = '0;
              dir_d = 1'b0;
            end else begin
              pos_d = pos_q - step_x[POS_W-1:0];
            end
          end
        end
        C_MODE_WRAP: begin
          dir_d = 1'b0;
          // step never exceeds one full lap, so a single subtraction
          // implements the modulo even when N_LED is not a power of two.
          if (sum_x > C_POS_MAX_X) begin
            pos_d = POS_W'(sum_x - C_POS_MOD_X);
          end else begin
            pos_d = sum_x[POS_W-1:0];
          end
        end
        C_MODE_FREEZE: begin
          pos_d = pos_q;
          dir_d = dir_q;
        end
        default: begin
          pos_d = pos_q;
          dir_d = dir_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      pwm_ctr_q <= '0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pwm_ctr_q <= pwm_ctr_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
    end
  end

  assign pos_o = pos_q;
  assign dir_o = dir_q;

  // --------------------------------------------------------------------------
  // Per-channel brightness and PWM
  // --------------------------------------------------------------------------
  logic [SEG_W-1:0] seg;
  logic [PWM_W-1:0] frac;
  logic             wrap_mode;
  logic             off_mode;

  assign seg       = pos_q[POS_W-1:FRAC_W];
  assign frac      = pos_q[FRAC_W-1 -: PWM_W];
  assign wrap_mode = (mode_i == C_MODE_WRAP);
  assign off_mode  = (mode_i == C_MODE_OFF);

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    // Neighbour segment indices; the wrapped ones only count in wrap mode.
    localparam logic [SEG_W-1:0] C_SELF       = SEG_W'(i);
    localparam logic [SEG_W-1:0] C_PREV       = SEG_W'((i == 0) ? N_LED - 1 : i - 1);
    localparam logic [SEG_W-1:0] C_NEXT       = SEG_W'((i == N_LED - 1) ? 0 : i + 1);
    localparam bit               C_PREV_WRAPS = (i == 0);
    localparam bit               C_NEXT_WRAPS = (i == N_LED - 1);

    logic [PWM_W-1:0] bright_q, bright_d;
    logic             led_q;

    always_comb begin
      bright_d = '0;
      if (off_mode) begin
        bright_d = '0;
      end else if (seg == C_SELF) begin
        bright_d = C_MAXB;
      end else if ((seg == C_PREV) && (!C_PREV_WRAPS || wrap_mode)) begin
        bright_d = frac;
      end else if ((seg == C_NEXT) && (!C_NEXT_WRAPS || wrap_mode)) begin
        bright_d = C_MAXB - frac;
      end
    end

    // Strict less-than: full scale gives (2^PWM_W-1)/2^PWM_W duty, 0 is dark.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bright_q <= '0;
        led_q    <= 1'b0;
      end else begin
        bright_q <= bright_d;
        led_q    <= (pwm_ctr_q < bright_q);
      end
    end

    assign led_o[i] = led_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_led_sweep_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_sweep_pwm
// Description : Directed self-checking bench for led_sweep_pwm with
//               N_LED=4, PWM_W=4, FRAC_W=4, PRESC=2, STEP_W=4 (POS_MAX=63).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sweep_pwm;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [3:0] step;
  logic [3:0] led;
  logic       dir;
  logic [5:0] pos;

  int checks   = 0;
  int failures = 0;
  int hi_cnt [4];

  led_sweep_pwm #(
    .N_LED  (4),
    .PWM_W  (4),
    .FRAC_W (4),
    .PRESC  (2),
    .STEP_W (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mode_i (mode),
    .step_i (step),
    .led_o  (led),
    .dir_o  (dir),
    .pos_o  (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset across one edge, then release with the given mode/step.
  // Afterwards presc = 0, so every even edge counted from here is a tick.
  task automatic apply_reset(input logic [1:0] m, input logic [3:0] s);
    rst  = 1'b1;
    mode = m;
    step = s;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Count high samples per channel over one full PWM period.
  task automatic measure_pwm();
    for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
    repeat (16) begin
      for (int c = 0; c < 4; c++) hi_cnt[c] += int'(led[c]);
      wait_edges(1);
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    mode = 2'd0;
    step = 4'd1;
    wait_edges(3);
    checks++; if (pos !== 6'd0) begin failures++; $display("FAIL reset_pos: got %0d expected 0", pos); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir: got %0d expected 0", dir); end
    checks++; if (led !== 4'h0) begin failures++; $display("FAIL reset_led: got %h expected 0", led); end
    rst = 1'b0;
  endtask

  task automatic test_bounce_sweep();
    apply_reset(2'd0, 4'd1);
    wait_edges(1);
    checks++; if (pos !== 6'd0) begin failures++; $display("FAIL bounce_first_cycle_pos: got %0d expected 0", pos); end
    wait_edges(1);
    checks++; if (pos !== 6'd1) begin failures++; $display("FAIL bounce_first_tick_pos: got %0d expected 1", pos); end
    wait_edges(123);  // edge 125
    checks++; if (pos !== 6'd62 || dir !== 1'b0) begin failures++; $display("FAIL bounce_pre_top: got pos=%0d dir=%0d expected pos=62 dir=0", pos, dir); end
    wait_edges(1);    // edge 126, tick 63
    checks++; if (pos !== 6'd63 || dir !== 1'b1) begin failures++; $display("FAIL bounce_top: got pos=%0d dir=%0d expected pos=63 dir=1", pos, dir); end
    wait_edges(1);
    checks++; if (pos !== 6'd63 || dir !== 1'b1) begin failures++; $display("FAIL bounce_top_hold: got pos=%0d dir=%0d expected pos=63 dir=1", pos, dir); end
    wait_edges(1);    // edge 128
    checks++; if (pos !== 6'd62 || dir !== 1'b1) begin failures++; $display("FAIL bounce_down_first: got pos=%0d dir=%0d expected pos=62 dir=1", pos, dir); end
    wait_edges(124);  // edge 252, tick 126
    checks++; if (pos !== 6'd0 || dir !== 1'b0) begin failures++; $display("FAIL bounce_bottom: got pos=%0d dir=%0d expected pos=0 dir=0", pos, dir); end
    wait_edges(2);
    checks++; if (pos !== 6'd1 || dir !== 1'b0) begin failures++; $display("FAIL bounce_repeat: got pos=%0d dir=%0d expected pos=1 dir=0", pos, dir); end
  endtask

  task automatic test_brightness_pwm();
    int exp_cnt [4];
    exp_cnt = '{10, 15, 5, 0};
    apply_reset(2'd0, 4'd1);
    wait_edges(42);
    checks++; if (pos !== 6'h15) begin failures++; $display("FAIL bright_preload_pos: got %0d expected 21", pos); end
    mode = 2'd2;
    wait_edges(3);
    measure_pwm();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (hi_cnt[c] !== exp_cnt[c]) begin failures++; $display("FAIL bright_pwm_ch%0d: got %0d expected %0d", c, hi_cnt[c], exp_cnt[c]); end
    end
    checks++; if (pos !== 6'h15) begin failures++; $display("FAIL freeze_hold_pos: got %0d expected 21", pos); end
  endtask

  task automatic test_wrap();
    int exp_wrap [4];
    int exp_bnc  [4];
    exp_wrap = '{8, 0, 7, 15};
    exp_bnc  = '{0, 0, 7, 15};
    apply_reset(2'd0, 4'd1);
    wait_edges(124);
    checks++; if (pos !== 6'd62 || dir !== 1'b0) begin failures++; $display("FAIL wrap_preload: got pos=%0d dir=%0d expected pos=62 dir=0", pos, dir); end
    mode = 2'd1;
    step = 4'd3;
    wait_edges(1);
    checks++; if (pos !== 6'd62) begin failures++; $display("FAIL wrap_no_tick_hold: got %0d expected 62", pos); end
    wait_edges(1);
    checks++; if (pos !== 6'd1 || dir !== 1'b0) begin failures++; $display("FAIL wrap_modulo: got pos=%0d dir=%0d expected pos=1 dir=0", pos, dir); end

    apply_reset(2'd0, 4'd1);
    wait_edges(112);
    checks++; if (pos !== 6'h38) begin failures++; $display("FAIL wrap_preload_56: got %0d expected 56", pos); end
    mode = 2'd1;
    step = 4'd0;
    wait_edges(3);
    measure_pwm();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (hi_cnt[c] !== exp_wrap[c]) begin failures++; $display("FAIL wrap_bright_ch%0d: got %0d expected %0d", c, hi_cnt[c], exp_wrap[c]); end
    end
    mode = 2'd0;
    wait_edges(3);
    measure_pwm();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (hi_cnt[c] !== exp_bnc[c]) begin failures++; $display("FAIL bounce_bright_ch%0d: got %0d expected %0d", c, hi_cnt[c], exp_bnc[c]); end
    end
    checks++; if (pos !== 6'h38 || dir !== 1'b0) begin failures++; $display("FAIL step0_hold: got pos=%0d dir=%0d expected pos=56 dir=0", pos, dir); end
  endtask

  task automatic test_endpoint_clamp();
    apply_reset(2'd0, 4'd15);
    wait_edges(8);
    checks++; if (pos !== 6'd60 || dir !== 1'b0) begin failures++; $display("FAIL clamp_preload: got pos=%0d dir=%0d expected pos=60 dir=0", pos, dir); end
    wait_edges(2);
    checks++; if (pos !== 6'd63 || dir !== 1'b1) begin failures++; $display("FAIL clamp_top: got pos=%0d dir=%0d expected pos=63 dir=1", pos, dir); end
    wait_edges(1);
    checks++; if (pos !== 6'd63 || dir !== 1'b1) begin failures++; $display("FAIL clamp_top_hold: got pos=%0d dir=%0d expected pos=63 dir=1", pos, dir); end
    wait_edges(1);
    checks++; if (pos !== 6'd48 || dir !== 1'b1) begin failures++; $display("FAIL clamp_down: got pos=%0d dir=%0d expected pos=48 dir=1", pos, dir); end
    wait_edges(6);
    checks++; if (pos !== 6'd3 || dir !== 1'b1) begin failures++; $display("FAIL clamp_pre_bottom: got pos=%0d dir=%0d expected pos=3 dir=1", pos, dir); end
    wait_edges(2);
    checks++; if (pos !== 6'd0 || dir !== 1'b0) begin failures++; $display("FAIL clamp_bottom: got pos=%0d dir=%0d expected pos=0 dir=0", pos, dir); end
  endtask

  task automatic test_mode_switch();
    apply_reset(2'd0, 4'd15);
    wait_edges(10);
    mode = 2'd1;
    step = 4'd1;
    wait_edges(1);
    checks++; if (pos !== 6'd63 || dir !== 1'b1) begin failures++; $display("FAIL switch_wrap_wait_tick: got pos=%0d dir=%0d expected pos=63 dir=1", pos, dir); end
    wait_edges(1);
    checks++; if (pos !== 6'd0 || dir !== 1'b0) begin failures++; $display("FAIL switch_wrap_clear_dir: got pos=%0d dir=%0d expected pos=0 dir=0", pos, dir); end
    mode = 2'd0;
    wait_edges(2);
    checks++; if (pos !== 6'd1 || dir !== 1'b0) begin failures++; $display("FAIL switch_bounce_up: got pos=%0d dir=%0d expected pos=1 dir=0", pos, dir); end
  endtask

  task automatic test_off_freeze();
    int bad_led;
    int bad_pos;
    bad_led = 0;
    bad_pos = 0;
    apply_reset(2'd0, 4'd15);
    wait_edges(12);
    checks++; if (pos !== 6'd48 || dir !== 1'b1) begin failures++; $display("FAIL off_preload: got pos=%0d dir=%0d expected pos=48 dir=1", pos, dir); end
    mode = 2'd3;
    wait_edges(2);
    for (int k = 0; k < 100; k++) begin
      if (led !== 4'h0) bad_led++;
      if (pos !== 6'd48 || dir !== 1'b1) bad_pos++;
      wait_edges(1);
    end
    checks++; if (bad_led !== 0) begin failures++; $display("FAIL off_led_dark: got %0d lit cycles expected 0", bad_led); end
    checks++; if (bad_pos !== 0) begin failures++; $display("FAIL off_pos_hold: got %0d moved cycles expected 0", bad_pos); end
    mode = 2'd0;
    wait_edges(1);
    checks++; if (pos !== 6'd48) begin failures++; $display("FAIL resume_wait_tick: got %0d expected 48", pos); end
    wait_edges(1);
    checks++; if (pos !== 6'd33 || dir !== 1'b1) begin failures++; $display("FAIL resume_motion: got pos=%0d dir=%0d expected pos=33 dir=1", pos, dir); end
  endtask

  task automatic test_async_reset();
    apply_reset(2'd0, 4'd15);
    wait_edges(12);
    step = 4'd8;
    wait_edges(2);
    checks++; if (pos !== 6'd40 || dir !== 1'b1) begin failures++; $display("FAIL areset_preload: got pos=%0d dir=%0d expected pos=40 dir=1", pos, dir); end
    checks++; if (led === 4'h0) begin failures++; $display("FAIL areset_led_lit: got %h expected nonzero", led); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (pos !== 6'd0) begin failures++; $display("FAIL areset_pos: got %0d expected 0", pos); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL areset_dir: got %0d expected 0", dir); end
    checks++; if (led !== 4'h0) begin failures++; $display("FAIL areset_led: got %h expected 0", led); end
    @(posedge clk);
    #1;
    mode = 2'd0;
    step = 4'd1;
    rst  = 1'b0;
    wait_edges(1);
    checks++; if (pos !== 6'd0) begin failures++; $display("FAIL areset_release_hold: got %0d expected 0", pos); end
    wait_edges(1);
    checks++; if (pos !== 6'd1 || dir !== 1'b0) begin failures++; $display("FAIL areset_first_update: got pos=%0d dir=%0d expected pos=1 dir=0", pos, dir); end
  endtask

  initial begin
    rst  = 1'b1;
    mode = 2'd0;
    step = 4'd0;
    test_reset();
    test_bounce_sweep();
    test_brightness_pwm();
    test_wrap();
    test_endpoint_clamp();
    test_mode_switch();
    test_off_freeze();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
